// File: rtl/aes_encrypt_sequencer.sv
// Iterative AES encryption: one round per clock over a shared round datapath,
// with valid/ready handshakes on both the request and ciphertext sides.
module aes_encrypt_sequencer #(
    parameter int Width = 128,
    parameter int Nk    = 4,
    parameter int Nr    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [Width-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    output logic [3:0]       round
);
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_t;

    localparam int NW = 4 * (Nr + 1);
    localparam logic [3:0] LAST_MID = 4'(Nr - 1);
    localparam logic [3:0] LAST     = 4'(Nr);
    localparam logic [79:0] RCON = 80'h01020408102040801b36;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 4; i++) o[127-32*i -: 32] = sub_word(s[127-32*i -: 32]);
        return o;
    endfunction

    // Byte n of the state sits at bits [127-8n -: 8]; n = row + 4*column.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    fsm_t             fsm_q, fsm_d;
    logic [127:0]     state_q, state_d;
    logic [Width-1:0] key_q, key_d;
    logic [3:0]       round_q, round_d;
    logic             out_valid_q, out_valid_d;
    logic [127:0]     rk [Nr+1];

    // Combinational key schedule from the latched key; each word is its own net.
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
        logic [31:0] word;
        if (gi < Nk) begin : g_key
            assign word = key_q[Width-1-32*gi -: 32];
        end else if (gi % Nk == 0) begin : g_rot
            assign word = g_word[gi-Nk].word
                        ^ sub_word({g_word[gi-1].word[23:0], g_word[gi-1].word[31:24]})
                        ^ {RCON[79-8*(gi/Nk-1) -: 8], 24'h000000};
        end else if (Nk > 6 && gi % Nk == 4) begin : g_sub
            assign word = g_word[gi-Nk].word ^ sub_word(g_word[gi-1].word);
        end else begin : g_xor
            assign word = g_word[gi-Nk].word ^ g_word[gi-1].word;
        end
    end

    for (genvar gi = 0; gi <= Nr; gi++) begin : g_rk
        assign rk[gi] = {g_word[4*gi].word, g_word[4*gi+1].word,
                         g_word[4*gi+2].word, g_word[4*gi+3].word};
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        key_d       = key_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Round key 0 is the raw key, so whitening needs no expansion.
                    state_d = in_data ^ in_key[Width-1 -: 128];
                    key_d   = in_key;
                    round_d = 4'd1;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = mix_columns(shift_rows(sub_bytes(state_q))) ^ rk[round_q];
                round_d = round_q + 4'd1;
                if (round_q == LAST_MID) fsm_d = S_FINAL;
            end
            S_FINAL: begin
                state_d     = shift_rows(sub_bytes(state_q)) ^ rk[Nr];
                round_d     = LAST;
                out_valid_d = 1'b1;
                fsm_d       = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    round_d     = 4'd0;
                    out_valid_d = 1'b0;
                    fsm_d       = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            key_q       <= '0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? state_q : '0;
    assign busy      = (fsm_q != S_IDLE);
    assign round     = round_q;
endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
// Scoreboard bench for aes_encrypt_sequencer: a byte-array AES model with a
// field-arithmetic S-box predicts each accepted request's ciphertext.
module tb_aes_encrypt_sequencer;
    localparam int NK = 4;
    localparam int NR = 10;
    localparam int W  = 128;
    localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, busy;
    logic [127:0] in_data = '0, out_data;
    logic [W-1:0] in_key = '0;
    logic [3:0]   round;

    aes_encrypt_sequencer #(.Width(W), .Nk(NK), .Nr(NR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .round(round)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           errors = 0, checks = 0, acc_count = 0, lat_a;
    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           rise_q[$];
    logic [7:0]   sbox [256];
    bit           prev_ov = 1'b0, rand_or = 1'b0;
    logic [127:0] hold_data;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine map of the multiplicative inverse in GF(2^8).
    task automatic build_sbox();
        logic [7:0] inv, r, s;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s ^= r;
            end
            sbox[v] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [W-1:0] key);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   a [4];
        logic [31:0]  w [4*(NR+1)];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8];
        for (int i = 0; i < NK; i++) w[i] = key[W-1-32*i -: 32];
        rc = 8'h01;
        for (int i = NK; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % NK == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-NK] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[4*c+r] ^= w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) tmp[r+4*c] = st[r+4*((c+r)%4)];
            st = tmp;
            if (rnd < NR) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = st[4*c+r];
                    for (int r = 0; r < 4; r++)
                        st[4*c+r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4])
                                  ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[4*c+r] ^= w[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
        return o;
    endfunction

    // Monitor: records acceptances into the scoreboard and checks every presented result.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(aes_ref(in_data, in_key));
                acc_q.push_back(cyc);
                acc_count++;
            end
            if (out_valid) begin
                chk("in_ready_low_while_valid", 128'(in_ready), 128'(0));
                if (!prev_ov) begin
                    if (acc_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_out_valid: got data %h want no result", out_data);
                    end else begin
                        lat_a = acc_q.pop_front();
                        chk("latency", 128'(cyc - lat_a - 1), 128'(NR));
                        rise_q.push_back(cyc);
                    end
                    hold_data = out_data;
                end else begin
                    chk("out_data_stable", out_data, hold_data);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ciphertext: got %h want nothing queued", out_data);
                    end else begin
                        chk("ciphertext", out_data, exp_q.pop_front());
                    end
                end
            end else begin
                chk("out_data_zero", out_data, 128'(0));
            end
            prev_ov = out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_or) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic present(input logic [127:0] pt, input logic [W-1:0] key,
                           input bit hold, output int acc);
        @(posedge clk); #1;
        in_data  = pt;
        in_key   = key;
        in_valid = 1'b1;
        acc      = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 within 100 cycles");
        end
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [127:0] d);
        bit got = 1'b0;
        d = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) begin
                d = out_data;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL out_timeout: got out_valid=0 want 1 within 300 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=%0d want 0 within 400 cycles", busy);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 100000 cycles");
        $fatal(1);
    end

    logic [127:0] d;
    int           a1, a2, acc_before;
    bit           seen;

    initial begin
        build_sbox();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_round", 128'(round), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        // FIPS-197 App. B, single pulse of out_valid.
        out_ready = 1'b1;
        present(B_PT, B_KY, 1'b0, a1);
        wait_out(d);
        chk("appB_ct", d, B_CT);
        @(negedge clk);
        chk("appB_valid_one_cycle", 128'(out_valid), 128'(0));
        chk("appB_in_ready_after", 128'(in_ready), 128'(1));

        // FIPS-197 C.1 with round stepping.
        present(C_PT, C_KY, 1'b0, a1);
        for (int k = 1; k <= NR; k++) begin
            @(negedge clk);
            chk("round_step", 128'(round), 128'(k));
        end
        wait_out(d);
        chk("c1_ct", d, C_CT);

        // Backpressure for 20 cycles.
        wait_idle();
        out_ready = 1'b0;
        present(B_PT, B_KY, 1'b0, a1);
        wait_out(d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_data", out_data, d);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        chk("bp_release_valid", 128'(out_valid), 128'(0));

        // Input isolation: in_valid held, data swapped, key churned.
        acc_before = acc_count;
        present(B_PT, B_KY, 1'b1, a1);
        in_data = C_PT;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            if (out_valid) begin
                d = out_data;
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("iso_seen", 128'(seen), 128'(1));
        chk("iso_ct", d, B_CT);
        @(negedge clk);
        chk("iso_accepts", 128'(acc_count - acc_before), 128'(1));

        // Back-to-back with in_valid held.
        wait_idle();
        rise_q.delete();
        present(B_PT, B_KY, 1'b1, a1);
        present(C_PT, C_KY, 1'b0, a2);
        chk("b2b_accept_gap", 128'(a2 - a1), 128'(NR + 2));
        wait_idle();
        chk("b2b_results", 128'(rise_q.size()), 128'(2));
        if (rise_q.size() == 2) chk("b2b_result_gap", 128'(rise_q[1] - rise_q[0]), 128'(NR + 2));

        // Random requests with random backpressure.
        rand_or = 1'b1;
        for (int n = 0; n < 8; n++)
            present({$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, a1);
        wait_idle();
        rand_or = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        chk("rand_drained", 128'(exp_q.size()), 128'(0));

        // Reset in the middle of round 5 discards the request.
        present(C_PT, C_KY, 1'b0, a1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (round == 4'd5) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_reach_round5", 128'(seen), 128'(1));
        #2;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_round", 128'(round), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        present(C_PT, C_KY, 1'b0, a1);
        wait_out(d);
        chk("post_mid_rst_ct", d, C_CT);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
